// File: rtl/min_detect_stream.sv
// Block-floating-point exponent detector: tracks the per-group minimum of re/im
// leading-sign counts over BLOCK_LEN accepted beats and reports it once per block.
module min_detect_stream #(
    parameter int CNT_W     = 5,
    parameter int LANES     = 16,
    parameter int GROUPS    = 2,
    parameter int BLOCK_LEN = 32,
    parameter int CNT_MAX   = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_cnt_re  [0:LANES-1],
    input  logic [CNT_W-1:0] i_cnt_im  [0:LANES-1],
    output logic             o_valid,
    output logic [CNT_W-1:0] o_min_cnt [0:GROUPS-1],
    output logic [CNT_W-1:0] o_min_all,
    output logic             o_busy
);

    localparam int GL    = LANES / GROUPS;
    localparam int CTR_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0] CMAX     = CNT_W'(CNT_MAX);

    if (LANES % GROUPS != 0) begin : g_bad_groups
        $error("min_detect_stream: LANES must be a multiple of GROUPS");
    end
    if (BLOCK_LEN < 1) begin : g_bad_block
        $error("min_detect_stream: BLOCK_LEN must be at least 1");
    end
    if (CNT_MAX > (2 ** CNT_W) - 1) begin : g_bad_max
        $error("min_detect_stream: CNT_MAX exceeds the count width");
    end

    logic [CTR_W-1:0] beat_cnt;
    logic [CTR_W-1:0] beat_idx;
    logic             beat_first;
    logic             beat_last;
    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;
    logic [CNT_W-1:0] beat_min  [0:GROUPS-1];
    logic [CNT_W-1:0] s1_min    [0:GROUPS-1];
    logic [CNT_W-1:0] acc       [0:GROUPS-1];
    logic [CNT_W-1:0] candidate [0:GROUPS-1];
    logic [CNT_W-1:0] clamped   [0:GROUPS-1];
    logic [CNT_W-1:0] clamped_all;

    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            beat_min[g] = '1;
            for (int l = 0; l < GL; l++) begin
                if (i_cnt_re[g*GL+l] < beat_min[g]) beat_min[g] = i_cnt_re[g*GL+l];
                if (i_cnt_im[g*GL+l] < beat_min[g]) beat_min[g] = i_cnt_im[g*GL+l];
            end
        end
    end

    // A clear makes the incoming beat index 0 of a fresh block
    assign beat_idx   = i_clear ? '0 : beat_cnt;
    assign beat_first = (beat_idx == '0);
    assign beat_last  = (beat_idx == LAST_IDX);

    always_comb begin
        clamped_all = CMAX;
        for (int g = 0; g < GROUPS; g++) begin
            candidate[g] = (s1_first || (s1_min[g] < acc[g])) ? s1_min[g] : acc[g];
            clamped[g]   = (candidate[g] > CMAX) ? CMAX : candidate[g];
            if (clamped[g] < clamped_all) clamped_all = clamped[g];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            o_valid   <= 1'b0;
            o_min_all <= CMAX;
            for (int g = 0; g < GROUPS; g++) begin
                s1_min[g]    <= '1;
                acc[g]       <= '1;
                o_min_cnt[g] <= CMAX;
            end
        end else begin
            o_valid  <= 1'b0;
            s1_valid <= i_valid;
            s1_first <= beat_first;
            s1_last  <= beat_last;
            if (i_valid) begin
                beat_cnt <= beat_last ? '0 : beat_idx + CTR_W'(1);
                for (int g = 0; g < GROUPS; g++) s1_min[g] <= beat_min[g];
            end else begin
                beat_cnt <= beat_idx;
            end
            // Clear wins over a block whose last beat is sitting in stage 1
            if (i_clear) begin
                for (int g = 0; g < GROUPS; g++) acc[g] <= '1;
            end else if (s1_valid) begin
                for (int g = 0; g < GROUPS; g++) acc[g] <= candidate[g];
                if (s1_last) begin
                    o_valid   <= 1'b1;
                    o_min_all <= clamped_all;
                    for (int g = 0; g < GROUPS; g++) o_min_cnt[g] <= clamped[g];
                end
            end
        end
    end

    assign o_busy = (beat_cnt != '0) || s1_valid;

endmodule
